// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch sequencer.
// Optional feature macro used by the fetch block: IFETCH_ZERO_HALT_EN.
package ifetch_pkg;

   localparam int XLEN       = 64;
   localparam int ILEN       = 32;
   localparam int INST_BYTES = 4;

   // Canonical no-op (addi x0, x0, 0)
   localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

   // One instruction buffer slot: fetch address plus fetched word
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } ifetch_entry_t;

   // Force a byte address onto a word boundary
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, inst} entries for decode.
// Flush empties it in one cycle; the head outputs hold the last shown entry when empty.
import ifetch_pkg::*;

module ifetch_buffer #(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  ifetch_entry_t           push_entry,
   input  logic                    pop,
   input  logic                    flush,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    head_valid,
   output ifetch_entry_t           head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   ifetch_entry_t  mem_r [DEPTH];
   ifetch_entry_t  hold_r;
   logic [PW-1:0]  wr_ptr_r;
   logic [PW-1:0]  rd_ptr_r;
   logic [CW-1:0]  count_r;
   logic           push_ok_s;
   logic           pop_ok_s;

   assign push_ok_s  = push && !flush;
   assign pop_ok_s   = pop && !flush && (count_r != CW'(0));
   assign count      = count_r;
   assign head_valid = (count_r != CW'(0));
   assign head       = head_valid ? mem_r[rd_ptr_r] : hold_r;

   // Entry storage: write the incoming word at the tail
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {$bits(ifetch_entry_t){1'b0}};
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_entry;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Pointer and occupancy bookkeeping, flush wins over push/pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else if (flush) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         else           wr_ptr_r <= wr_ptr_r;
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         else           rd_ptr_r <= rd_ptr_r;
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Remember the last presented head so decode sees stable values when empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_r <= {$bits(ifetch_entry_t){1'b0}};
      end else if (head_valid) begin
         hold_r <= mem_r[rd_ptr_r];
      end else begin
         hold_r <= hold_r;
      end
   end

   ifetch_buffer_chk #(.DEPTH(DEPTH)) u_chk (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .flush (flush),
      .count (count_r)
   );

endmodule

// File: rtl/ifetch_buffer_chk.sv
// Property checker for the instruction buffer: a push must never land on a full buffer.
module ifetch_buffer_chk #(
   parameter int DEPTH = 2
) (
   input logic                     clk,
   input logic                     reset,
   input logic                     push,
   input logic                     flush,
   input logic [$clog2(DEPTH):0]   count
);

   // The fetch credit scheme must leave room for every accepted response
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      (push && !flush) |-> (32'(count) < DEPTH));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues word fetches under a credit limit,
// tracks in-flight responses, discards stale ones after redirects and feeds decode.
// Optional feature macro: IFETCH_ZERO_HALT_EN (halt on an all-zero fetched word).
import ifetch_pkg::*;

module instr_fetch_ctrl #(
   parameter logic [63:0] RESET_PC        = 64'h0,
   parameter int          BUF_DEPTH       = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic         clk,
   input  logic         reset,
   output logic         Imem_Req,
   output logic [63:0]  Imem_Addr,
   input  logic         Imem_Gnt,
   input  logic         Imem_Rvalid,
   input  logic [31:0]  Imem_Rdata,
   output logic         Inst_Valid,
   input  logic         Inst_Ready,
   output logic [31:0]  Instruction,
   output logic [63:0]  Inst_PC,
   input  logic         Redirect_Valid,
   input  logic [63:0]  Redirect_PC,
   output logic         Halted
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   logic [63:0]    pc_r;
   logic [63:0]    resp_pc_r;
   logic [OW-1:0]  outstanding_r;
   logic [OW-1:0]  drop_r;
   logic           halted_r;

   logic [CW-1:0]  count_s;
   logic           head_valid_s;
   ifetch_entry_t  head_s;
   ifetch_entry_t  push_entry_s;
   logic [31:0]    inflight_s;
   logic           credit_ok_s;
   logic           fire_s;
   logic           rvalid_s;
   logic           drop_hit_s;
   logic           zero_hit_s;
   logic           push_s;
   logic           pop_s;
   logic [63:0]    redirect_pc_s;

   // A response with nothing outstanding is a stray and is ignored
   assign rvalid_s      = Imem_Rvalid && (outstanding_r != OW'(0));
   assign drop_hit_s    = rvalid_s && (drop_r != OW'(0));
   assign redirect_pc_s = word_align(Redirect_PC);

   // Buffered plus in-flight words may never exceed the buffer size
   assign inflight_s  = 32'(count_s) + 32'(outstanding_r);
   assign credit_ok_s = (inflight_s < 32'(BUF_DEPTH)) &&
                        (32'(outstanding_r) < 32'(MAX_OUTSTANDING));

   assign Imem_Req  = !reset && !halted_r && !Redirect_Valid && credit_ok_s;
   assign Imem_Addr = word_align(pc_r);
   assign fire_s    = Imem_Req && Imem_Gnt;

`ifdef IFETCH_ZERO_HALT_EN
   assign zero_hit_s = rvalid_s && (drop_r == OW'(0)) && !Redirect_Valid &&
                       (Imem_Rdata == 32'h0000_0000);
   assign Halted     = halted_r;
`else
   assign zero_hit_s = 1'b0;
   assign Halted     = 1'b0;
`endif

   assign push_s       = rvalid_s && (drop_r == OW'(0)) && !zero_hit_s && !Redirect_Valid;
   assign push_entry_s = '{pc: resp_pc_r, inst: Imem_Rdata};

   // Nothing is handed to decode in a redirect cycle, so no pop can happen then
   assign Inst_Valid  = head_valid_s && !Redirect_Valid;
   assign pop_s       = Inst_Valid && Inst_Ready;
   assign Instruction = head_s.inst;
   assign Inst_PC     = head_s.pc;

   // Fetch PC: redirect target, else advance one word per accepted request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r <= RESET_PC;
      end else if (Redirect_Valid) begin
         pc_r <= redirect_pc_s;
      end else if (fire_s) begin
         pc_r <= pc_r + 64'(INST_BYTES);
      end else begin
         pc_r <= pc_r;
      end
   end

   // Address tag for the next kept response, advances only when a word is buffered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_pc_r <= RESET_PC;
      end else if (Redirect_Valid) begin
         resp_pc_r <= redirect_pc_s;
      end else if (push_s) begin
         resp_pc_r <= resp_pc_r + 64'(INST_BYTES);
      end else begin
         resp_pc_r <= resp_pc_r;
      end
   end

   // In-flight count: up on grant, down on any answered response (kept or dropped)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding_r <= OW'(0);
      end else begin
         outstanding_r <= outstanding_r + OW'(fire_s) - OW'(rvalid_s);
      end
   end

   // Number of upcoming responses to discard after a redirect or a halt
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_r <= OW'(0);
      end else if (Redirect_Valid) begin
         drop_r <= outstanding_r - OW'(rvalid_s);
      end else if (zero_hit_s) begin
         drop_r <= outstanding_r - OW'(1) + OW'(fire_s);
      end else if (drop_hit_s) begin
         drop_r <= drop_r - OW'(1);
      end else begin
         drop_r <= drop_r;
      end
   end

   // Halt flag: set by a kept zero word, cleared only by a redirect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halted_r <= 1'b0;
      end else if (Redirect_Valid) begin
         halted_r <= 1'b0;
      end else if (zero_hit_s) begin
         halted_r <= 1'b1;
      end else begin
         halted_r <= halted_r;
      end
   end

   ifetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .flush      (Redirect_Valid),
      .count      (count_s),
      .head_valid (head_valid_s),
      .head       (head_s)
   );

endmodule
